// File: rtl/mem_bus_arbiter.sv
// N-channel arbiter for the shared RAM port; one-cycle arbitration, then owner's access is muxed straight through.
// Backpressure: ram_wait goes to the owner's ch_wait, all other channels see ch_wait=1 until granted.
module mem_bus_arbiter #(
  parameter int NCH      = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCH-1:0]           ch_ren,
  input  logic [NCH-1:0]           ch_wen,
  input  logic [NCH-1:0]           ch_lock,
  input  logic [NCH*AW-1:0]        ch_addr,
  input  logic [NCH*DW-1:0]        ch_store,
  output logic [NCH-1:0]           ch_wait,
  output logic [DW-1:0]            ch_load,
  output logic                     ram_ren,
  output logic                     ram_wen,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_store,
  input  logic [DW-1:0]            ram_load,
  input  logic                     ram_wait,
  output logic [$clog2(NCH)-1:0]   grant_id,
  output logic                     busy
);

  localparam int GW = $clog2(NCH);
  localparam int HW = $clog2(MAX_HOLD + 1) + 1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [NCH-1:0]  req;
  logic [NCH-1:0]  g_onehot;
  logic [GW-1:0]   winner;
  logic            found;
  logic            g_req;
  logic            g_lock;
  logic            others_req;
  logic            complete;
  logic            hold_hit;
  logic            release_own;

  assign req = ch_ren | ch_wen;

  // Search starts at rr_ptr in round-robin mode, at index 0 in fixed mode.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      if (RR_MODE != 0) idx = (int'(rr_ptr_q) + k) % NCH;
      else              idx = k;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    g_onehot           = '0;
    g_onehot[grant_q]  = 1'b1;
  end

  assign g_req      = req[grant_q];
  assign g_lock     = ch_lock[grant_q];
  assign others_req = |(req & ~g_onehot);
  assign complete   = (state_q == OWN) && g_req && !ram_wait;
  assign hold_hit   = (MAX_HOLD != 0) && ((int'(hold_q) + 1) >= MAX_HOLD);

  // A hold-limit release overrides lock so a long block transfer cannot starve the others.
  assign release_own = (state_q == OWN) &&
                       ((!g_req && !g_lock) ||
                        (complete && !g_lock) ||
                        (complete && hold_hit && others_req));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          grant_d = winner;
          if (RR_MODE != 0)
            rr_ptr_d = (winner == GW'(NCH - 1)) ? '0 : winner + 1'b1;
        end
      end
      OWN: begin
        if (release_own) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (complete && (int'(hold_q) < MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    ch_wait   = '1;
    if (state_q == OWN) begin
      ram_addr  = ch_addr[int'(grant_q)*AW +: AW];
      ram_store = ch_store[int'(grant_q)*DW +: DW];
      if (g_req) begin
        // Write takes precedence when a channel raises both strobes.
        ram_wen          = ch_wen[grant_q];
        ram_ren          = ch_ren[grant_q] & ~ch_wen[grant_q];
        ch_wait[grant_q] = ram_wait;
      end
    end
  end

  assign ch_load  = ram_load;
  assign grant_id = grant_q;
  assign busy     = (state_q == OWN);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a 2-channel round-robin instance (hold limit 4) fed by a word engine and
// checked against a completion scoreboard, plus a 4-channel fixed-priority instance for reset/priority.
module tb_mem_bus_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic        nRST_a;
  logic [1:0]  a_ren, a_wen, a_lock, a_ch_wait;
  logic [63:0] a_addr, a_store;
  logic [31:0] a_ch_load, a_ram_addr, a_ram_store, a_ram_load;
  logic        a_ram_ren, a_ram_wen, a_ram_wait, a_busy;
  logic [0:0]  a_grant;

  logic         nRST_b;
  logic [3:0]   b_ren, b_wen, b_lock, b_ch_wait;
  logic [127:0] b_addr, b_store;
  logic [31:0]  b_ch_load, b_ram_addr, b_ram_store, b_ram_load;
  logic         b_ram_ren, b_ram_wen, b_ram_wait, b_busy;
  logic [1:0]   b_grant;

  mem_bus_arbiter #(.NCH(2), .AW(32), .DW(32), .RR_MODE(1), .MAX_HOLD(4)) dut_a (
    .CLK(CLK), .nRST(nRST_a), .ch_ren(a_ren), .ch_wen(a_wen), .ch_lock(a_lock),
    .ch_addr(a_addr), .ch_store(a_store), .ch_wait(a_ch_wait), .ch_load(a_ch_load),
    .ram_ren(a_ram_ren), .ram_wen(a_ram_wen), .ram_addr(a_ram_addr), .ram_store(a_ram_store),
    .ram_load(a_ram_load), .ram_wait(a_ram_wait), .grant_id(a_grant), .busy(a_busy)
  );

  mem_bus_arbiter #(.NCH(4), .AW(32), .DW(32), .RR_MODE(0), .MAX_HOLD(8)) dut_b (
    .CLK(CLK), .nRST(nRST_b), .ch_ren(b_ren), .ch_wen(b_wen), .ch_lock(b_lock),
    .ch_addr(b_addr), .ch_store(b_store), .ch_wait(b_ch_wait), .ch_load(b_ch_load),
    .ram_ren(b_ram_ren), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr), .ram_store(b_ram_store),
    .ram_load(b_ram_load), .ram_wait(b_ram_wait), .grant_id(b_grant), .busy(b_busy)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  // Per-channel word engine state for dut_a: remaining words, current address, modes.
  int          rem[2];
  logic [31:0] cur[2];
  logic [31:0] dat[2];
  bit          lockm[2];
  bit          wem[2];
  bit          done[2];
  bit          stall;
  bit          slow;
  bit          a_half;

  // Engine: applies channel/RAM inputs 2 ns after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      for (int c = 0; c < 2; c++) begin
        if (done[c]) begin
          done[c] = 1'b0;
          if (rem[c] > 0) rem[c] = rem[c] - 1;
          cur[c] = cur[c] + 32'd4;
        end
        a_ren[c]            = (rem[c] > 0);
        a_wen[c]            = (rem[c] > 0) && wem[c];
        a_lock[c]           = lockm[c] && (rem[c] > 1);
        a_addr[c*32 +: 32]  = cur[c];
        a_store[c*32 +: 32] = dat[c];
      end
      a_ram_wait = stall ? 1'b1 : (slow ? !a_half : 1'b0);
    end
  end

  // Scoreboard monitor on dut_a, sampled on the falling edge.
  initial begin : mon
    exp_t       e;
    logic [1:0] exp_w;
    forever begin
      @(negedge CLK);
      if (a_busy && (a_ram_ren || a_ram_wen) && !a_ram_wait) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: ch%0d addr=%h completed, nothing expected", a_grant, a_ram_addr);
        end else begin
          e     = sb.pop_front();
          exp_w = 2'b11;
          exp_w[e.ch] = 1'b0;
          if (int'(a_grant) != e.ch || a_ram_addr !== e.addr || a_ram_wen !== e.wen ||
              a_ram_ren !== !e.wen || a_ram_store !== e.data || a_ch_wait !== exp_w) begin
            fails++;
            $display("FAIL sb_access: got ch%0d addr=%h ren=%b wen=%b store=%h wait=%b, want ch%0d addr=%h wen=%b store=%h wait=%b",
                     a_grant, a_ram_addr, a_ram_ren, a_ram_wen, a_ram_store, a_ch_wait,
                     e.ch, e.addr, e.wen, e.data, exp_w);
          end
        end
        done[a_grant] = 1'b1;
      end else if (!a_busy) begin
        tests++;
        if (a_ram_ren !== 1'b0 || a_ram_wen !== 1'b0 || a_ch_wait !== 2'b11) begin
          fails++;
          $display("FAIL idle_outputs: ren=%b wen=%b ch_wait=%b, want 0 0 11", a_ram_ren, a_ram_wen, a_ch_wait);
        end
      end
      a_half = (a_ram_ren || a_ram_wen) && a_ram_wait;
    end
  end

  task automatic pulse_a();
    @(negedge CLK);
    #1;
    for (int c = 0; c < 2; c++) begin
      rem[c] = 0; done[c] = 1'b0; lockm[c] = 1'b0; wem[c] = 1'b0;
    end
    stall  = 1'b0;
    slow   = 1'b0;
    nRST_a = 1'b0;
    @(posedge CLK);
    #3;
    nRST_a = 1'b1;
  endtask

  task automatic drain(input int bound, output int cyc);
    cyc = 0;
    while (sb.size() != 0 && cyc < bound) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rem[0] = 1; rem[1] = 1;
    cur[0] = 32'h10; cur[1] = 32'h20;
    stall  = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    tests++;
    if (a_busy !== 1'b0 || a_ram_ren !== 1'b0 || a_ram_wen !== 1'b0 || a_ram_addr !== 32'h0 ||
        a_ram_store !== 32'h0 || a_ch_wait !== 2'b11 || a_grant !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: busy=%b ren=%b wen=%b addr=%h store=%h wait=%b grant=%0d, want 0 0 0 0 0 11 0",
               a_busy, a_ram_ren, a_ram_wen, a_ram_addr, a_ram_store, a_ch_wait, a_grant);
    end
    tests++;
    if (a_ch_load !== 32'h5A5A_1234) begin
      fails++;
      $display("FAIL ch_load_bcast: got %h want 5a5a1234", a_ch_load);
    end
    @(posedge CLK);
    #3;
    nRST_a = 1'b1;
    @(negedge CLK);
    tests++;
    if (a_busy !== 1'b0 || a_ram_ren !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_cycle: busy=%b ren=%b, want 0 0", a_busy, a_ram_ren);
    end
    @(negedge CLK);
    tests++;
    if (a_busy !== 1'b1 || a_grant !== 1'b0 || a_ram_addr !== 32'h10 || a_ram_ren !== 1'b1 || a_ch_wait !== 2'b11) begin
      fails++;
      $display("FAIL reset_first_grant: busy=%b grant=%0d addr=%h ren=%b wait=%b, want 1 0 00000010 1 11",
               a_busy, a_grant, a_ram_addr, a_ram_ren, a_ch_wait);
    end
    #1;
    rem[0] = 0; rem[1] = 0;
    @(negedge CLK);
    tests++;
    if (a_busy !== 1'b1 || a_ram_ren !== 1'b0 || a_ram_wen !== 1'b0) begin
      fails++;
      $display("FAIL owner_idle_gap: busy=%b ren=%b wen=%b, want 1 0 0", a_busy, a_ram_ren, a_ram_wen);
    end
    @(negedge CLK);
    tests++;
    if (a_busy !== 1'b0) begin
      fails++;
      $display("FAIL release_no_req: busy=%b want 0", a_busy);
    end
    stall = 1'b0;
  endtask

  task automatic test_rr_alternate();
    int cyc;
    pulse_a();
    @(negedge CLK);
    #1;
    cur[0] = 32'h1000; cur[1] = 32'h2000;
    dat[0] = 32'hA0A0_0000; dat[1] = 32'hB1B1_0000;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{0, 32'h1000 + 32'(4*i), 1'b0, 32'hA0A0_0000});
      sb.push_back('{1, 32'h2000 + 32'(4*i), 1'b0, 32'hB1B1_0000});
    end
    rem[0] = 3; rem[1] = 3;
    drain(40, cyc);
    tests++;
    if (sb.size() != 0 || cyc != 12) begin
      fails++;
      $display("FAIL rr_alternate: %0d left after %0d cycles, want 0 left after 12", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic test_write_priority();
    int cyc;
    pulse_a();
    @(negedge CLK);
    #1;
    cur[1] = 32'h40; dat[1] = 32'hDEAD_BEEF; wem[1] = 1'b1;
    sb.push_back('{1, 32'h40, 1'b1, 32'hDEAD_BEEF});
    rem[1] = 1;
    drain(20, cyc);
    tests++;
    if (sb.size() != 0 || cyc != 2) begin
      fails++;
      $display("FAIL write_priority: %0d left after %0d cycles, want 0 left after 2", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic test_lock_fill();
    int cyc;
    pulse_a();
    @(negedge CLK);
    #1;
    slow = 1'b1;
    cur[0] = 32'h100; lockm[0] = 1'b1; dat[0] = 32'hA0A0_0000;
    cur[1] = 32'h2000; dat[1] = 32'hB1B1_0000;
    sb.push_back('{0, 32'h100, 1'b0, 32'hA0A0_0000});
    sb.push_back('{0, 32'h104, 1'b0, 32'hA0A0_0000});
    sb.push_back('{1, 32'h2000, 1'b0, 32'hB1B1_0000});
    rem[0] = 2; rem[1] = 1;
    drain(40, cyc);
    tests++;
    if (sb.size() != 0 || cyc != 8) begin
      fails++;
      $display("FAIL lock_fill: %0d left after %0d cycles, want 0 left after 8", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic test_max_hold();
    int cyc;
    pulse_a();
    @(negedge CLK);
    #1;
    cur[0] = 32'h3000; lockm[0] = 1'b1; dat[0] = 32'hA0A0_0000;
    cur[1] = 32'h4000; dat[1] = 32'hB1B1_0000;
    for (int i = 0; i < 4; i++) sb.push_back('{0, 32'h3000 + 32'(4*i), 1'b0, 32'hA0A0_0000});
    sb.push_back('{1, 32'h4000, 1'b0, 32'hB1B1_0000});
    for (int i = 4; i < 10; i++) sb.push_back('{0, 32'h3000 + 32'(4*i), 1'b0, 32'hA0A0_0000});
    rem[0] = 10; rem[1] = 1;
    drain(60, cyc);
    tests++;
    if (sb.size() != 0 || cyc != 14) begin
      fails++;
      $display("FAIL max_hold: %0d left after %0d cycles, want 0 left after 14", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic test_fixed_reset();
    b_ren = 4'b1010;
    b_addr[32 +: 32] = 32'h111;
    b_addr[96 +: 32] = 32'h333;
    b_ram_wait = 1'b1;
    @(posedge CLK);
    #3;
    nRST_b = 1'b1;
    @(negedge CLK);
    tests++;
    if (b_busy !== 1'b0 || b_ram_ren !== 1'b0) begin
      fails++;
      $display("FAIL fixed_first_cycle: busy=%b ren=%b, want 0 0", b_busy, b_ram_ren);
    end
    @(negedge CLK);
    tests++;
    if (b_busy !== 1'b1 || b_grant !== 2'd1 || b_ram_ren !== 1'b1 || b_ram_addr !== 32'h111) begin
      fails++;
      $display("FAIL fixed_lowest: busy=%b grant=%0d ren=%b addr=%h, want 1 1 1 00000111", b_busy, b_grant, b_ram_ren, b_ram_addr);
    end
    #1;
    nRST_b = 1'b0;
    #1;
    tests++;
    if (b_ram_ren !== 1'b0 || b_ram_wen !== 1'b0 || b_busy !== 1'b0 || b_ch_wait !== 4'hF || b_ram_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_access: ren=%b wen=%b busy=%b wait=%b addr=%h, want 0 0 0 1111 0",
               b_ram_ren, b_ram_wen, b_busy, b_ch_wait, b_ram_addr);
    end
    @(posedge CLK);
    #3;
    nRST_b = 1'b1;
    @(negedge CLK);
    tests++;
    if (b_busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: busy=%b want 0", b_busy);
    end
    @(negedge CLK);
    tests++;
    if (b_grant !== 2'd1 || b_ram_addr !== 32'h111 || b_busy !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_regrant: grant=%0d addr=%h busy=%b, want 1 00000111 1", b_grant, b_ram_addr, b_busy);
    end
    #1;
    b_ram_wait = 1'b0;
    #1;
    tests++;
    if (b_ch_wait !== 4'b1101 || b_ch_load !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL fixed_owner_wait: wait=%b load=%h, want 1101 0badf00d", b_ch_wait, b_ch_load);
    end
    @(posedge CLK);
    #1;
    b_ren[1] = 1'b0;
    @(negedge CLK);
    tests++;
    if (b_busy !== 1'b0) begin
      fails++;
      $display("FAIL fixed_release: busy=%b want 0", b_busy);
    end
    @(negedge CLK);
    tests++;
    if (b_busy !== 1'b1 || b_grant !== 2'd3 || b_ram_addr !== 32'h333 || b_ram_ren !== 1'b1 || b_ch_wait !== 4'b0111) begin
      fails++;
      $display("FAIL fixed_next: busy=%b grant=%0d addr=%h ren=%b wait=%b, want 1 3 00000333 1 0111",
               b_busy, b_grant, b_ram_addr, b_ram_ren, b_ch_wait);
    end
    #1;
    b_ren = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST_a = 1'b1;
    nRST_b = 1'b1;
    a_ren = '0; a_wen = '0; a_lock = '0; a_addr = '0; a_store = '0;
    a_ram_load = 32'h5A5A_1234;
    a_ram_wait = 1'b1;
    b_ren = '0; b_wen = '0; b_lock = '0; b_addr = '0; b_store = '0;
    b_ram_load = 32'h0BAD_F00D;
    b_ram_wait = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rem[c] = 0; cur[c] = '0; dat[c] = '0; lockm[c] = 1'b0; wem[c] = 1'b0; done[c] = 1'b0;
    end
    stall  = 1'b1;
    slow   = 1'b0;
    a_half = 1'b0;
    #1;
    nRST_a = 1'b0;
    nRST_b = 1'b0;
    test_reset();
    test_rr_alternate();
    test_write_priority();
    test_lock_fill();
    test_max_hold();
    test_fixed_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-channel arbiter for the shared RAM port behind the cache layer.
- Generalises the fixed single-core i/d pairing to NCH cache request channels, for example icache/dcache per core in multicore builds.
- Supports fixed-priority or round-robin mode, multi-word lock for block fills and writebacks, and an anti-starvation hold limit.
- Sits between the cache controllers and the memory controller/RAM.

Parameters:
NCH, 2, number of request channels (2..8)
AW, 32, address width
DW, 32, data width
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
MAX_HOLD, 8, max completed accesses per grant while another channel is pending; 0 = unlimited

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous reset, active-low
ch_ren  in  NCH  per-channel read request
ch_wen  in  NCH  per-channel write request
ch_lock  in  NCH  keep grant across consecutive words (block transfer)
ch_addr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW]
ch_store  in  NCH*DW  per-channel write data, same packing
ch_wait  out  NCH  per-channel wait; low = access completes this cycle
ch_load  out  DW  read data, broadcast to all channels
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  AW  RAM address
ram_store  out  DW  RAM write data
ram_load  in  DW  RAM read data
ram_wait  in  1  RAM busy; low with a strobe = access done this cycle
grant_id  out  clog2(NCH)  current owner (valid when busy)
busy  out  1  a channel owns the bus

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, grant_id=0, busy=0, rr_ptr=0, hold_cnt=0.
  - ram_ren/ram_wen=0, ram_addr/ram_store=0, all ch_wait=1.
- States: IDLE, OWN.
- Request definition: channel i requests when ch_ren[i] | ch_wen[i].
- IDLE:
  - RAM outputs are 0; all ch_wait are 1.
  - If any channel requests, a winner is chosen and registered into grant_id; next state is OWN.
  - Arbitration latency is one cycle from request to first RAM strobe.
- Winner selection:
  - RR_MODE=1: first requesting index at or after rr_ptr, wrapping modulo NCH. On grant, rr_ptr <= winner+1, wrapping NCH-1 -> 0.
  - RR_MODE=0: lowest requesting index; rr_ptr is unused.
- OWN, with g = grant_id:
  - ram_* are combinational muxes of channel g.
  - If ch_ren[g] and ch_wen[g] are both high, the write wins and ram_ren=0.
  - ch_wait[g] = ram_wait when channel g requests, else 1.
  - ch_wait of every other channel is 1.
  - ch_load = ram_load in all states.
- Completion: in OWN, channel g requests and ram_wait=0. hold_cnt increments, saturating at MAX_HOLD.
- Release from OWN to IDLE, hold_cnt cleared, happens when any of the following holds:
  - (a) channel g is not requesting and ch_lock[g]=0, evaluated in the same cycle; RAM strobes are 0 that cycle.
  - (b) a completion occurs and ch_lock[g]=0.
  - (c) a completion occurs, MAX_HOLD!=0, hold_cnt+1 >= MAX_HOLD, and any other channel requests. This forced release ignores ch_lock.
- Lock behaviour: with ch_lock[g]=1 and no request, the grant is retained and RAM strobes are 0. This covers gaps between words of a block transfer.
- Simultaneous new request and release: the released owner is not re-granted in round-robin mode if others pend, because rr_ptr has already advanced. In fixed mode, lower indices always win.
- ram_wait asserted indefinitely: the grant is held with no timeout.
- Reset mid-access: strobes drop immediately (async) and the transaction is abandoned. Channels must reissue.
- Every access takes at least 2 cycles from an idle bus (arbitrate + access). A locked owner's back-to-back words complete at the RAM rate.

Test Plan:
- Reset with all requests high, release nRST -> first cycle busy=0, ram_ren=0; next cycle busy=1, grant_id=0, ram_addr=ch_addr[0].
- RR_MODE=1, NCH=2, ch0 and ch1 reading continuously, lock=0, ram_wait=0 -> grants alternate 0,1,0,1; each completion is followed by one IDLE cycle; ch_wait low only for the owner.
- ch1 ren+wen both high, addr=0x40, store=0xDEADBEEF -> ram_wen=1, ram_ren=0, ram_addr=0x40, ram_store=0xDEADBEEF.
- ch0 locked 2-word fill (0x100, 0x104) with ch1 pending, ram_wait=0 for 2 cycles per word -> ch0 completes both words without a ch1 grant; after lock drops, ch1 is granted within 2 cycles.
- MAX_HOLD=4, ch0 lock held with 10 words, ch1 pending -> forced release after the 4th ch0 completion; ch1 is served; ch0 then reacquires the bus.
- RR_MODE=0, NCH=4, channels 1 and 3 requesting, nRST pulsed low mid-access -> ram strobes are 0 during reset; afterwards channel 1 is granted before channel 3.
